// File: rtl/cordic_req_scheduler_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] FT_QNAN = 32'h7FC0_0000;

    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_req_scheduler_if.sv
// Requester and accelerator signals of the scheduler; slave is the scheduler's view.
interface cordic_req_scheduler_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_x;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_y;
    logic                    resp_err;
    logic                    acc_start;
    logic [DATA_W-1:0]       acc_x;
    logic                    acc_done;
    logic [DATA_W-1:0]       acc_y;
    logic                    busy;

    modport master (
        output req_valid, req_x, acc_done, acc_y,
        input  req_ack, resp_valid, resp_y, resp_err, acc_start, acc_x, busy
    );

    modport slave (
        input  req_valid, req_x, acc_done, acc_y,
        output req_ack, resp_valid, resp_y, resp_err, acc_start, acc_x, busy
    );
endinterface

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request strictly after ptr, wrapping.
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        int unsigned cand;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!any && req[ID_W'(cand)]) begin
                any = 1'b1;
                idx = ID_W'(cand);
            end
        end
        grant = N_REQ'(any) << idx;
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one multi-cycle CORDIC accelerator between N_REQ requesters with
// round-robin arbitration and a watchdog on the accelerator's done strobe.
module cordic_req_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WDOG_CYC = 256
) (
    input logic                   clk,
    input logic                   reset_n,
    input logic                   clk_en,
    cordic_req_scheduler_if.slave bus
);

    localparam int unsigned ID_W = id_w(N_REQ);
    localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, id_q, id_d;
    logic [N_REQ-1:0]    oh_q, oh_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [DATA_W-1:0]   acc_x_q, acc_x_d, res_q, res_d, resp_y_q, resp_y_d;
    logic                err_q, err_d, resp_err_q, resp_err_d;
    logic                acc_start_q, acc_start_d, busy_q, busy_d;
    logic [N_REQ-1:0]    req_ack_q, req_ack_d, resp_valid_q, resp_valid_d;

    logic [N_REQ-1:0]    grant_c;
    logic [ID_W-1:0]     grant_id_c;
    logic                grant_any_c;
    logic [DATA_W-1:0]   x_slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign x_slice[g] = bus.req_x[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_c),
        .idx   (grant_id_c),
        .any   (grant_any_c)
    );

    // Next-state and registered-output values; everything holds unless a state acts.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        oh_d         = oh_q;
        wdog_d       = wdog_q;
        acc_x_d      = acc_x_q;
        res_d        = res_q;
        err_d        = err_q;
        resp_y_d     = resp_y_q;
        req_ack_d    = '0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        acc_start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any_c) begin
                    id_d    = grant_id_c;
                    oh_d    = grant_c;
                    acc_x_d = x_slice[grant_id_c];
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ack_d = oh_q;
                state_d   = ISSUE;
            end
            ISSUE: begin
                acc_start_d = 1'b1;
                wdog_d      = WD_W'(WDOG_CYC);
                state_d     = WAIT;
            end
            WAIT: begin
                // A done strobe on the last watchdog cycle still delivers the real result.
                if (bus.acc_done) begin
                    res_d   = bus.acc_y;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wdog_q <= WD_W'(1)) begin
                    res_d   = DATA_W'(FT_QNAN);
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q - WD_W'(1);
                end
            end
            RESP: begin
                resp_valid_d = oh_q;
                resp_y_d     = res_q;
                resp_err_d   = err_q;
                rr_ptr_d     = id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            oh_q         <= '0;
            wdog_q       <= '0;
            acc_x_q      <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            resp_y_q     <= '0;
            resp_err_q   <= 1'b0;
            acc_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            req_ack_q    <= '0;
            resp_valid_q <= '0;
        end else if (clk_en) begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            oh_q         <= oh_d;
            wdog_q       <= wdog_d;
            acc_x_q      <= acc_x_d;
            res_q        <= res_d;
            err_q        <= err_d;
            resp_y_q     <= resp_y_d;
            resp_err_q   <= resp_err_d;
            acc_start_q  <= acc_start_d;
            busy_q       <= busy_d;
            req_ack_q    <= req_ack_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_y     = resp_y_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.acc_start  = acc_start_q;
    assign bus.acc_x      = acc_x_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Scoreboard bench for cordic_req_scheduler with a behavioural accelerator model.
module tb_cordic_req_scheduler;
    import cordic_sched_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned WD = 256;

    typedef struct {
        int         id;
        logic [W-1:0] y;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic clk_en = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_x = '0;
    logic model_done = 1'b0, spur_done = 1'b0;
    logic [W-1:0] model_y = '0;

    exp_t resp_q[$];
    int   ack_q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, start_cyc = 0, resp_cyc = 0, n_ack = 0;
    int   lat = 20;
    bit   never = 1'b0, hold_req = 1'b0, edge_en = 1'b0;

    always #5 clk = ~clk;

    cordic_req_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();
    assign bus.req_valid = req_valid;
    assign bus.req_x     = req_x;
    assign bus.acc_done  = model_done | spur_done;
    assign bus.acc_y     = model_y;

    cordic_req_scheduler #(.N_REQ(N), .DATA_W(W), .WDOG_CYC(WD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .bus     (bus)
    );

    function automatic logic [W-1:0] acc_fn(input logic [W-1:0] x);
        return {~x[W-1], x[W-2:0]} ^ 32'h0012_3400;
    endfunction

    // Accelerator model: result strobe lat enabled edges after the sampled start.
    initial begin
        bit s, en, rn, pending;
        int cnt;
        logic [W-1:0] xs, xl;
        pending = 1'b0; cnt = 0; xl = '0;
        forever begin
            @(negedge clk); #2;
            s = bus.acc_start; en = clk_en; rn = reset_n; xs = bus.acc_x;
            @(posedge clk); #1;
            edge_en = en && rn && reset_n;
            if (!reset_n || !rn) begin
                pending = 1'b0; model_done = 1'b0;
            end else if (en) begin
                model_done = 1'b0;
                if (s && !never) begin pending = 1'b1; cnt = lat; xl = xs; end
                if (pending) begin
                    cnt--;
                    if (cnt <= 0) begin model_done = 1'b1; model_y = acc_fn(xl); pending = 1'b0; end
                end
            end
        end
    end

    // Scoreboard: every new ack/response pulse is checked against the queues.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            cyc++;
            if (edge_en) begin
                if (bus.acc_start === 1'b1) start_cyc = cyc;
                if (bus.req_ack !== '0) begin
                    total++; n_ack++;
                    if (ack_q.size() == 0) begin
                        bad++; $display("FAIL ack_unexpected got=%b required=none", bus.req_ack);
                    end else begin
                        a = ack_q.pop_front();
                        if (bus.req_ack !== (N'(1) << a)) begin
                            bad++; $display("FAIL ack_id got=%b required=%b", bus.req_ack, N'(1) << a);
                        end
                    end
                end
                if (bus.resp_valid !== '0) begin
                    total++; resp_cyc = cyc;
                    if (resp_q.size() == 0) begin
                        bad++; $display("FAIL resp_unexpected got=%b y=%h", bus.resp_valid, bus.resp_y);
                    end else begin
                        e = resp_q.pop_front();
                        if (bus.resp_valid !== (N'(1) << e.id) || bus.resp_y !== e.y || bus.resp_err !== e.err) begin
                            bad++;
                            $display("FAIL resp got=%b/%h/%b required=%b/%h/%b", bus.resp_valid, bus.resp_y,
                                     bus.resp_err, N'(1) << e.id, e.y, e.err);
                        end
                    end
                end else begin
                    total++;
                    if (bus.resp_err !== 1'b0) begin
                        bad++; $display("FAIL resp_err_idle got=%b required=0", bus.resp_err);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (!hold_req) req_valid = req_valid & ~bus.req_ack;
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (resp_q.size() == 0 && ack_q.size() == 0 && bus.busy === 1'b0) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d busy=%b required=drained", name, resp_q.size(), bus.busy);
            resp_q.delete(); ack_q.delete();
        end
        step();
    endtask

    task automatic post(input int id, input logic [W-1:0] x, input bit err);
        req_x[id*W +: W] = x;
        ack_q.push_back(id);
        resp_q.push_back('{id, err ? W'(FT_QNAN) : acc_fn(x), err});
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ack, bus.resp_valid, bus.resp_y, bus.resp_err, bus.acc_start, bus.acc_x, bus.busy} !== '0) begin
            bad++; $display("FAIL reset_outputs ack=%b rv=%b y=%h start=%b x=%h busy=%b required=0",
                            bus.req_ack, bus.resp_valid, bus.resp_y, bus.acc_start, bus.acc_x, bus.busy);
        end
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        int base;
        lat = 3; hold_req = 1'b1; base = n_ack;
        for (int i = 0; i < 5; i++) post(i % N, 32'h3F80_0000 + 32'(i % N), 1'b0);
        req_valid = '1;
        for (int n = 0; n < 200 && n_ack < base + 5; n++) step();
        req_valid = '0; hold_req = 1'b0;
        total++;
        if (n_ack != base + 5) begin bad++; $display("FAIL rr_ack_count got=%0d required=5", n_ack - base); end
        wait_drain(100, "rr");
    endtask

    task automatic test_single();
        lat = 20;
        post(0, 32'h4360_0000, 1'b0);
        req_valid = 4'b0001;
        step();
        total++;
        if (bus.busy !== 1'b1 || bus.req_ack !== '0) begin
            bad++; $display("FAIL single_e0 busy=%b ack=%b required=1/0000", bus.busy, bus.req_ack);
        end
        step();
        total++;
        if (bus.req_ack !== 4'b0001 || bus.acc_start !== 1'b0) begin
            bad++; $display("FAIL single_e1 ack=%b start=%b required=0001/0", bus.req_ack, bus.acc_start);
        end
        step();
        total++;
        if (bus.acc_start !== 1'b1 || bus.acc_x !== 32'h4360_0000 || bus.req_ack !== '0) begin
            bad++; $display("FAIL single_e2 start=%b x=%h required=1/43600000", bus.acc_start, bus.acc_x);
        end
        wait_drain(100, "single");
        total++;
        if (resp_cyc - start_cyc != lat + 2) begin
            bad++; $display("FAIL single_latency got=%0d required=%0d", resp_cyc - start_cyc, lat + 2);
        end
    endtask

    task automatic test_watchdog();
        never = 1'b1;
        post(2, 32'h4049_0FDB, 1'b1);
        req_valid = 4'b0100;
        wait_drain(WD + 50, "wdog");
        total++;
        if (resp_cyc - start_cyc != WD + 1) begin
            bad++; $display("FAIL wdog_latency got=%0d required=%0d", resp_cyc - start_cyc, WD + 1);
        end
        never = 1'b0; lat = 5;
        post(3, 32'h3F00_0000, 1'b0);
        req_valid = 4'b1000;
        wait_drain(60, "after_wdog");
    endtask

    task automatic test_collision();
        lat = WD - 1;
        post(1, 32'hC0A0_0000, 1'b0);
        req_valid = 4'b0010;
        wait_drain(WD + 50, "collide");
        total++;
        if (resp_cyc - start_cyc != WD + 1) begin
            bad++; $display("FAIL collide_latency got=%0d required=%0d", resp_cyc - start_cyc, WD + 1);
        end
    endtask

    task automatic test_reset_mid();
        lat = 5;
        post(1, 32'h4000_0000, 1'b0);
        req_valid = 4'b0010;
        wait_drain(60, "pre_reset");
        lat = 50;
        req_x[3*W +: W] = 32'h4100_0000;
        ack_q.push_back(3);
        req_valid = 4'b1000;
        for (int n = 0; n < 14; n++) step();
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ack, bus.resp_valid, bus.resp_y, bus.resp_err, bus.acc_start, bus.acc_x, bus.busy} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs y=%h x=%h busy=%b required=0", bus.resp_y, bus.acc_x, bus.busy);
        end
        total++;
        if (ack_q.size() != 0) begin bad++; $display("FAIL reset_mid_ack got=%0d required=0", ack_q.size()); end
        step(); step(); step();
        reset_n = 1'b1;
        lat = 4;
        post(0, 32'h4110_0000, 1'b0);
        post(2, 32'h4120_0000, 1'b0);
        req_valid = 4'b0101;
        wait_drain(100, "post_reset");
    endtask

    task automatic test_stall();
        bit seen = 1'b0;
        lat = 20;
        post(2, 32'h4260_0000, 1'b0);
        req_valid = 4'b0100;
        for (int n = 0; n < 10 && !seen; n++) begin step(); seen = (bus.acc_start === 1'b1); end
        clk_en = 1'b0;
        for (int n = 0; n < 10; n++) step();
        total++;
        if (bus.acc_start !== 1'b1 || bus.busy !== 1'b1 || !seen) begin
            bad++; $display("FAIL stall_start start=%b busy=%b required=1/1", bus.acc_start, bus.busy);
        end
        clk_en = 1'b1;
        for (int n = 0; n < 5; n++) step();
        clk_en = 1'b0;
        for (int n = 0; n < 10; n++) step();
        clk_en = 1'b1;
        wait_drain(100, "stall");
        total++;
        if (resp_cyc - start_cyc != lat + 22) begin
            bad++; $display("FAIL stall_latency got=%0d required=%0d", resp_cyc - start_cyc, lat + 22);
        end
        spur_done = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            total++;
            if ({bus.req_ack, bus.resp_valid, bus.acc_start, bus.busy} !== '0) begin
                bad++; $display("FAIL spurious_done ack=%b rv=%b start=%b busy=%b required=0",
                                bus.req_ack, bus.resp_valid, bus.acc_start, bus.busy);
            end
        end
        spur_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_watchdog();
        test_collision();
        test_reset_mid();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
